// File: rtl/interrupt_sequencer.sv
// Interrupt entry/exit sequencer for the pipelined core: drains the pipeline,
// pushes the return address, fetches the ISR vector and tracks ISR execution.
module interrupt_sequencer #(
  parameter int         DRAIN_CYCLES = 4,
  parameter logic [7:0] VEC_ADDR     = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       intr,
  input  logic       rti_wb,
  input  logic       branch_pending,
  input  logic [7:0] pc_next,
  output logic       stall_fetch,
  output logic       flush_if,
  output logic       sf1,
  output logic [7:0] ret_addr,
  output logic       vec_rd,
  output logic [7:0] vec_addr,
  output logic       pc_load_vec,
  output logic       in_isr,
  output logic       int_pending
);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    SAVE,
    VECTOR,
    LOADPC,
    ISR
  } state_t;

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] count;
  logic [2:0] count_nxt;
  logic       intr_q;
  logic       intr_edge;
  logic       pending_nxt;
  logic [7:0] ret_nxt;

  assign intr_edge = intr & ~intr_q;
  assign vec_addr  = VEC_ADDR;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= 3'd0;
      intr_q      <= 1'b0;
      int_pending <= 1'b0;
      ret_addr    <= 8'h00;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      intr_q      <= intr;
      int_pending <= pending_nxt;
      ret_addr    <= ret_nxt;
    end
  end

  // Edges arriving outside IDLE collapse into a single pending request (no nesting).
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    pending_nxt = int_pending;
    ret_nxt     = ret_addr;

    if (intr_edge && (state != IDLE)) begin
      pending_nxt = 1'b1;
    end

    case (state)
      IDLE: begin
        if (intr_edge || int_pending) begin
          state_nxt   = DRAIN;
          count_nxt   = DRAIN_LOAD;
          pending_nxt = 1'b0;
        end
      end
      DRAIN: begin
        if (count != 3'd0) begin
          count_nxt = count - 3'd1;
        end else if (!branch_pending) begin
          ret_nxt   = pc_next;
          state_nxt = SAVE;
        end
      end
      SAVE:    state_nxt = VECTOR;
      VECTOR:  state_nxt = LOADPC;
      LOADPC:  state_nxt = ISR;
      ISR: begin
        if (rti_wb) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall_fetch = 1'b0;
    flush_if    = 1'b0;
    sf1         = 1'b0;
    vec_rd      = 1'b0;
    pc_load_vec = 1'b0;
    in_isr      = 1'b0;

    case (state)
      DRAIN: begin
        stall_fetch = 1'b1;
        flush_if    = 1'b1;
      end
      SAVE: begin
        stall_fetch = 1'b1;
        sf1         = 1'b1;
      end
      VECTOR: begin
        stall_fetch = 1'b1;
        vec_rd      = 1'b1;
      end
      LOADPC: begin
        stall_fetch = 1'b1;
        pc_load_vec = 1'b1;
      end
      ISR:     in_isr = 1'b1;
      default: ;
    endcase
  end

  // A second push of the same return address would corrupt the stack.
  a_sf1_single: assert property (@(posedge clk) disable iff (rst) sf1 |=> !sf1);
  a_isr_no_stall: assert property (@(posedge clk) disable iff (rst) !(in_isr && stall_fetch));

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed self-checking bench for interrupt_sequencer; a second instance
// with DRAIN_CYCLES=1 shares the stimulus.
module tb_interrupt_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       intr;
  logic       rti_wb;
  logic       branch_pending;
  logic [7:0] pc_next;

  logic       stall_fetch, flush_if, sf1, vec_rd, pc_load_vec, in_isr, int_pending;
  logic [7:0] ret_addr, vec_addr;
  logic       stall_fetch_b, flush_if_b, sf1_b, vec_rd_b, pc_load_vec_b, in_isr_b, int_pending_b;
  logic [7:0] ret_addr_b, vec_addr_b;

  logic [6:0] outs;
  logic [6:0] outs_b;

  int tests_run    = 0;
  int tests_failed = 0;

  // Output vector order: {stall_fetch, flush_if, sf1, vec_rd, pc_load_vec, in_isr, int_pending}
  localparam logic [6:0] O_IDLE  = 7'b0000000;
  localparam logic [6:0] O_DRAIN = 7'b1100000;
  localparam logic [6:0] O_SAVE  = 7'b1010000;
  localparam logic [6:0] O_VEC   = 7'b1001000;
  localparam logic [6:0] O_LOAD  = 7'b1000100;
  localparam logic [6:0] O_ISR   = 7'b0000010;
  localparam logic [6:0] O_PEND  = 7'b0000001;

  assign outs   = {stall_fetch, flush_if, sf1, vec_rd, pc_load_vec, in_isr, int_pending};
  assign outs_b = {stall_fetch_b, flush_if_b, sf1_b, vec_rd_b, pc_load_vec_b, in_isr_b, int_pending_b};

  interrupt_sequencer dut (
    .clk(clk), .rst(rst), .intr(intr), .rti_wb(rti_wb),
    .branch_pending(branch_pending), .pc_next(pc_next),
    .stall_fetch(stall_fetch), .flush_if(flush_if), .sf1(sf1),
    .ret_addr(ret_addr), .vec_rd(vec_rd), .vec_addr(vec_addr),
    .pc_load_vec(pc_load_vec), .in_isr(in_isr), .int_pending(int_pending)
  );

  interrupt_sequencer #(.DRAIN_CYCLES(1), .VEC_ADDR(8'h80)) dut_short (
    .clk(clk), .rst(rst), .intr(intr), .rti_wb(rti_wb),
    .branch_pending(branch_pending), .pc_next(pc_next),
    .stall_fetch(stall_fetch_b), .flush_if(flush_if_b), .sf1(sf1_b),
    .ret_addr(ret_addr_b), .vec_rd(vec_rd_b), .vec_addr(vec_addr_b),
    .pc_load_vec(pc_load_vec_b), .in_isr(in_isr_b), .int_pending(int_pending_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance into the next cycle, drive its inputs, then check the state outputs.
  task automatic applyStimulus(input logic r, input logic i, input logic rt, input logic br,
                               input logic [7:0] pc, input logic [6:0] exp, input string tag);
    @(posedge clk);
    #1;
    rst            = r;
    intr           = i;
    rti_wb         = rt;
    branch_pending = br;
    pc_next        = pc;
    #1;
    checkOutput(tag, 32'(outs), 32'(exp));
  endtask

  task automatic resetDut(input logic i);
    rst            = 1'b1;
    intr           = i;
    rti_wb         = 1'b0;
    branch_pending = 1'b0;
    pc_next        = 8'h00;
    @(posedge clk);
    #1;
    checkOutput("rst_outs", 32'(outs), 32'(O_IDLE));
    checkOutput("rst_outs_short", 32'(outs_b), 32'(O_IDLE));
    checkOutput("rst_ret", 32'(ret_addr), 32'h00);
    checkOutput("rst_vec_addr", 32'(vec_addr), 32'h01);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [6:0] e;
    logic [6:0] e2;
    logic [7:0] pc;

    // Basic entry with default drain, plus the DRAIN_CYCLES=1 instance.
    resetDut(1'b0);
    for (int c = 1; c <= 22; c++) begin
      if (c <= 10)      e = O_IDLE;
      else if (c <= 14) e = O_DRAIN;
      else if (c == 15) e = O_SAVE;
      else if (c == 16) e = O_VEC;
      else if (c == 17) e = O_LOAD;
      else if (c <= 20) e = O_ISR;
      else              e = O_IDLE;
      if (c <= 10)      e2 = O_IDLE;
      else if (c == 11) e2 = O_DRAIN;
      else if (c == 12) e2 = O_SAVE;
      else if (c == 13) e2 = O_VEC;
      else if (c == 14) e2 = O_LOAD;
      else if (c <= 20) e2 = O_ISR;
      else              e2 = O_IDLE;
      if (c < 11)       pc = 8'h10;
      else if (c <= 14) pc = 8'h2A;
      else              pc = 8'h55;
      applyStimulus(1'b0, c == 10, c == 20, 1'b0, pc, e, $sformatf("basic_c%0d", c));
      checkOutput($sformatf("short_c%0d", c), 32'(outs_b), 32'(e2));
      if (c == 12) checkOutput("short_ret", 32'(ret_addr_b), 32'h2A);
      if (c == 15) checkOutput("basic_ret_save", 32'(ret_addr), 32'h2A);
      if (c == 18) checkOutput("basic_ret_hold", 32'(ret_addr), 32'h2A);
    end
    checkOutput("short_vec_addr", 32'(vec_addr_b), 32'h80);

    // Branch hold in DRAIN, then two edges during ISR and a single re-entry.
    resetDut(1'b0);
    for (int c = 1; c <= 43; c++) begin
      if (c <= 10)      e = O_IDLE;
      else if (c <= 20) e = O_DRAIN;
      else if (c == 21) e = O_SAVE;
      else if (c == 22) e = O_VEC;
      else if (c == 23) e = O_LOAD;
      else if (c <= 25) e = O_ISR;
      else if (c <= 29) e = O_ISR | O_PEND;
      else if (c == 30) e = O_IDLE | O_PEND;
      else if (c <= 34) e = O_DRAIN;
      else if (c == 35) e = O_SAVE;
      else if (c == 36) e = O_VEC;
      else if (c == 37) e = O_LOAD;
      else if (c <= 40) e = O_ISR;
      else              e = O_IDLE;
      pc = 8'(8'h60 + c);
      applyStimulus(1'b0, (c == 10) || (c == 25) || (c == 27), (c == 29) || (c == 40),
                    (c >= 11) && (c <= 19), pc, e, $sformatf("branch_c%0d", c));
      if (c == 21) checkOutput("branch_ret", 32'(ret_addr), 32'h74);
      if (c == 35) checkOutput("reentry_ret", 32'(ret_addr), 32'h82);
    end

    // RTI ignored in IDLE and DRAIN; reset asserted in VECTOR.
    resetDut(1'b0);
    for (int c = 1; c <= 16; c++) begin
      if (c <= 5)       e = O_IDLE;
      else if (c <= 9)  e = O_DRAIN;
      else if (c == 10) e = O_SAVE;
      else              e = O_IDLE;
      applyStimulus((c == 11) || (c == 12), c == 5, c <= 9, 1'b0, 8'h33, e,
                    $sformatf("rti_rst_c%0d", c));
      if (c == 11) checkOutput("rst_mid_ret", 32'(ret_addr), 32'h00);
    end

    // Reset asserted in SAVE: no sf1 afterwards.
    resetDut(1'b0);
    for (int c = 1; c <= 12; c++) begin
      if (c <= 2)      e = O_IDLE;
      else if (c <= 6) e = O_DRAIN;
      else             e = O_IDLE;
      applyStimulus(c == 7, c == 2, 1'b0, 1'b0, 8'h44, e, $sformatf("rst_save_c%0d", c));
    end

    // intr held high through reset release counts as one edge.
    resetDut(1'b1);
    for (int c = 1; c <= 12; c++) begin
      if (c <= 4)      e = O_DRAIN;
      else if (c == 5) e = O_SAVE;
      else if (c == 6) e = O_VEC;
      else if (c == 7) e = O_LOAD;
      else if (c <= 9) e = O_ISR;
      else             e = O_IDLE;
      applyStimulus(1'b0, 1'b1, c == 9, 1'b0, 8'h21, e, $sformatf("held_c%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
